// File: rtl/pcie_read_request_scheduler.sv
// Host-to-card DMA read request scheduler: walks a PIO-loaded page table, issues 512 B
// memory read requests to pcie_tx, and tracks a pool of read tags until their completions land.
module pcie_read_request_scheduler #(
  parameter int          TAGS     = 8,
  parameter logic [7:0]  TAG_BASE = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pio_write_valid,
  input  logic [12:0] pio_write_address,
  input  logic [63:0] pio_write_data,
  input  logic [9:0]  fifo_free_blocks,
  input  logic        completion_done,
  input  logic [7:0]  completion_done_tag,
  output logic        read_request_valid,
  output logic [63:0] read_request_address,
  output logic [7:0]  read_request_tag,
  input  logic        read_request_ready,
  output logic        active,
  output logic [19:0] request_count,
  output logic [5:0]  outstanding,
  output logic        complete,
  output logic        tag_error
);

  localparam int         SW        = (TAGS > 1) ? $clog2(TAGS) : 1;
  localparam logic [7:0] SLOT_MASK = 8'(TAGS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, REQUEST} state_t;

  state_t          state;
  logic [42:0]     page_table [32];
  logic [TAGS-1:0] busy;
  logic [19:0]     limit;
  logic [42:0]     page_q;
  logic [SW-1:0]   slot_q;

  // PIO decode
  logic enable_write, disable_write, limit_write, page_write;
  assign enable_write  = pio_write_valid && (pio_write_address == 13'd16);
  assign disable_write = pio_write_valid && (pio_write_address == 13'd17);
  assign limit_write   = pio_write_valid && (pio_write_address == 13'd18);
  assign page_write    = pio_write_valid && (pio_write_address[12:9] == 4'd2);

  // NOTE: the page table is plain storage that PIO loads before use, so it takes no reset;
  // keeping reset off the array lets it map onto RAM/LUT-RAM.
  always_ff @(posedge clock) begin
    if (page_write) page_table[pio_write_address[4:0]] <= pio_write_data[63:21];
  end

  // Lowest free tag slot; scanning downward lets the lowest index win.
  logic          free_found;
  logic [SW-1:0] free_slot;
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_slot  = SW'(i);
      end
    end
  end

  logic issue_ok;
  assign issue_ok = active && (request_count < limit) && free_found &&
                    (fifo_free_blocks > {4'd0, outstanding});

  // A retire is honoured only for an in-range tag that is currently in flight.
  logic          retire_in_range, retire_ok, fire;
  logic [SW-1:0] retire_slot;
  assign retire_slot     = completion_done_tag[SW-1:0];
  assign retire_in_range = ((completion_done_tag & ~SLOT_MASK) == TAG_BASE) &&
                           (int'(retire_slot) < TAGS);
  assign retire_ok       = completion_done && retire_in_range && busy[retire_slot];
  assign fire            = read_request_valid && read_request_ready;

  assign complete = active && (request_count == limit) && (outstanding == 6'd0);

  // Control registers, tag pool and in-flight count.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active        <= 1'b0;
      request_count <= '0;
      limit         <= '0;
      tag_error     <= 1'b0;
      busy          <= '0;
      outstanding   <= '0;
    end else begin
      if (enable_write && !active) begin
        active        <= 1'b1;
        request_count <= '0;
        tag_error     <= 1'b0;
      end else begin
        if (disable_write) active <= 1'b0;
        if (fire)          request_count <= request_count + 20'd1;
      end
      if (completion_done && !retire_ok) tag_error <= 1'b1;
      if (limit_write) limit <= pio_write_data[19:0];

      // Issue and retire never touch the same slot: a retire needs the slot already busy.
      if (fire)      busy[slot_q]      <= 1'b1;
      if (retire_ok) busy[retire_slot] <= 1'b0;
      case ({fire, retire_ok})
        2'b10:   outstanding <= outstanding + 6'd1;
        2'b01:   outstanding <= outstanding - 6'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Request FSM: IDLE latches page and tag, LOOKUP forms the request, REQUEST holds it until ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      page_q               <= '0;
      slot_q               <= '0;
      read_request_valid   <= 1'b0;
      read_request_address <= '0;
      read_request_tag     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_ok) begin
            page_q <= page_table[request_count[16:12]];
            slot_q <= free_slot;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!active || disable_write) begin
            state <= IDLE;
          end else begin
            read_request_address <= {page_q, request_count[11:0], 9'd0};
            read_request_tag     <= TAG_BASE | 8'(slot_q);
            read_request_valid   <= 1'b1;
            state                <= REQUEST;
          end
        end
        REQUEST: begin
          // Once raised, valid stays up until accepted, even if disabled meanwhile.
          if (read_request_ready) begin
            read_request_valid <= 1'b0;
            state              <= IDLE;
          end
        end
        default: begin
          read_request_valid <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_read_request_scheduler.sv
// Directed bench for pcie_read_request_scheduler: tag allocation, flow control, handshake hold,
// page crossing, tag errors and asynchronous reset.
module tb_pcie_read_request_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        pio_write_valid;
  logic [12:0] pio_write_address;
  logic [63:0] pio_write_data;
  logic [9:0]  fifo_free_blocks;
  logic        completion_done = 1'b0;
  logic [7:0]  completion_done_tag = 8'd0;
  logic        read_request_valid;
  logic [63:0] read_request_address;
  logic [7:0]  read_request_tag;
  logic        read_request_ready;
  logic        active;
  logic [19:0] request_count;
  logic [5:0]  outstanding;
  logic        complete;
  logic        tag_error;

  int checks = 0;
  int errors = 0;

  logic [63:0] fire_addr [$];
  logic [7:0]  fire_tag  [$];
  logic [7:0]  retire_q  [$];
  bit          auto_retire = 1'b0;

  localparam logic [12:0] A_ENABLE  = 13'd16;
  localparam logic [12:0] A_DISABLE = 13'd17;
  localparam logic [12:0] A_LIMIT   = 13'd18;
  localparam logic [12:0] A_PAGE0   = 13'h400;
  localparam logic [12:0] A_PAGE1   = 13'h401;
  localparam logic [63:0] BASE0     = 64'h0000_0001_0000_0000;
  localparam logic [63:0] BASE1     = 64'h0000_0002_0000_0000;

  pcie_read_request_scheduler #(.TAGS(8), .TAG_BASE(8'h00)) dut (
    .clock                (clock),
    .reset                (reset),
    .pio_write_valid      (pio_write_valid),
    .pio_write_address    (pio_write_address),
    .pio_write_data       (pio_write_data),
    .fifo_free_blocks     (fifo_free_blocks),
    .completion_done      (completion_done),
    .completion_done_tag  (completion_done_tag),
    .read_request_valid   (read_request_valid),
    .read_request_address (read_request_address),
    .read_request_tag     (read_request_tag),
    .read_request_ready   (read_request_ready),
    .active               (active),
    .request_count        (request_count),
    .outstanding          (outstanding),
    .complete             (complete),
    .tag_error            (tag_error)
  );

  always #5 clock = ~clock;

  // Completion driver: one queued tag per cycle, changed on the falling edge.
  always @(negedge clock) begin
    if (retire_q.size() > 0) begin
      completion_done     = 1'b1;
      completion_done_tag = retire_q.pop_front();
    end else begin
      completion_done     = 1'b0;
      completion_done_tag = 8'd0;
    end
  end

  // Handshake monitor, sampled 1 ns before the rising edge.
  always @(negedge clock) begin
    #4;
    if (!reset && read_request_valid && read_request_ready) begin
      fire_addr.push_back(read_request_address);
      fire_tag.push_back(read_request_tag);
      if (auto_retire) retire_q.push_back(read_request_tag);
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pio(input logic [12:0] a, input logic [63:0] d);
    @(negedge clock);
    pio_write_valid   = 1'b1;
    pio_write_address = a;
    pio_write_data    = d;
    @(negedge clock);
    pio_write_valid   = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!read_request_valid && n < max_cycles) begin
      tick(1);
      n++;
    end
    check("wait_valid", read_request_valid, 1);
  endtask

  task automatic clear_log();
    fire_addr.delete();
    fire_tag.delete();
  endtask

  initial begin
    reset              = 1'b1;
    pio_write_valid    = 1'b0;
    pio_write_address  = '0;
    pio_write_data     = '0;
    fifo_free_blocks   = 10'd100;
    read_request_ready = 1'b1;
    tick(2);
    check("rst_valid",       read_request_valid, 0);
    check("rst_active",      active, 0);
    check("rst_count",       request_count, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_complete",    complete, 0);
    check("rst_tag_error",   tag_error, 0);
    reset = 1'b0;

    // Three requests, limit 3; valid rises two clocks after enable takes effect.
    pio(A_PAGE0, BASE0);
    pio(A_PAGE1, BASE1);
    pio(A_LIMIT, 64'd3);
    pio(A_ENABLE, 64'd0);
    check("t1_valid_e0", read_request_valid, 0);
    tick(1);
    check("t1_valid_e1", read_request_valid, 0);
    tick(1);
    check("t1_valid_e2", read_request_valid, 1);
    tick(15);
    check("t1_fires", fire_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_tag",  fire_tag[i], 64'(i));
      check("t1_addr", fire_addr[i], BASE0 + 64'(i * 512));
    end
    check("t1_outstanding", outstanding, 3);
    check("t1_count",       request_count, 3);
    check("t1_complete",    complete, 0);
    check("t1_valid_low",   read_request_valid, 0);

    // Retire all three.
    retire_q.push_back(8'd0);
    retire_q.push_back(8'd1);
    retire_q.push_back(8'd2);
    tick(5);
    check("t2_outstanding", outstanding, 0);
    check("t2_complete",    complete, 1);
    check("t2_tag_error",   tag_error, 0);

    // Tag exhaustion with limit 20, then reuse of a retired tag.
    pio(A_DISABLE, 64'd0);
    check("t3_inactive", active, 0);
    pio(A_LIMIT, 64'd20);
    clear_log();
    pio(A_ENABLE, 64'd0);
    tick(40);
    check("t3_fires", fire_tag.size(), 8);
    for (int i = 0; i < 8; i++) check("t3_tag", fire_tag[i], 64'(i));
    check("t3_count",       request_count, 8);
    check("t3_outstanding", outstanding, 8);
    check("t3_valid_low",   read_request_valid, 0);
    retire_q.push_back(8'd3);
    tick(10);
    check("t3_fires_reuse", fire_tag.size(), 9);
    check("t3_reuse_tag",   fire_tag[8], 3);
    check("t3_count_reuse", request_count, 9);
    pio(A_DISABLE, 64'd0);
    for (int i = 0; i < 8; i++) retire_q.push_back(8'(i));
    tick(12);
    check("t3_drained", outstanding, 0);

    // Downstream buffer space limits issue.
    fifo_free_blocks = 10'd2;
    pio(A_LIMIT, 64'd10);
    clear_log();
    pio(A_ENABLE, 64'd0);
    tick(20);
    check("t4_fires_2",  fire_tag.size(), 2);
    check("t4_count_2",  request_count, 2);
    check("t4_out_2",    outstanding, 2);
    fifo_free_blocks = 10'd5;
    tick(20);
    check("t4_fires_5",  fire_tag.size(), 5);
    check("t4_count_5",  request_count, 5);
    check("t4_out_5",    outstanding, 5);
    check("t4_last_tag", fire_tag[4], 4);
    pio(A_DISABLE, 64'd0);
    for (int i = 0; i < 5; i++) retire_q.push_back(8'(i));
    tick(8);
    fifo_free_blocks = 10'd100;
    check("t4_drained", outstanding, 0);

    // Back-pressure: request held stable, disable mid-wait still completes it.
    read_request_ready = 1'b0;
    clear_log();
    pio(A_ENABLE, 64'd0);
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t5_hold_valid", read_request_valid, 1);
      check("t5_hold_addr",  read_request_address, BASE0);
      check("t5_hold_tag",   read_request_tag, 0);
    end
    pio(A_DISABLE, 64'd0);
    check("t5_inactive",     active, 0);
    check("t5_still_valid",  read_request_valid, 1);
    read_request_ready = 1'b1;
    tick(10);
    check("t5_fires",        fire_tag.size(), 1);
    check("t5_count",        request_count, 1);
    check("t5_outstanding",  outstanding, 1);
    check("t5_valid_low",    read_request_valid, 0);
    retire_q.push_back(8'd0);
    tick(3);
    check("t5_drained", outstanding, 0);

    // Page crossing at request 4096 with automatic retirement.
    pio(A_LIMIT, 64'd4097);
    clear_log();
    auto_retire = 1'b1;
    pio(A_ENABLE, 64'd0);
    for (int n = 0; n < 14000 && request_count != 20'd4097; n++) tick(1);
    check("t6_count", request_count, 4097);
    tick(10);
    auto_retire = 1'b0;
    check("t6_outstanding", outstanding, 0);
    check("t6_complete",    complete, 1);
    check("t6_fires",       fire_addr.size(), 4097);
    if (fire_addr.size() == 4097) begin
      check("t6_addr_4095", fire_addr[4095], 64'h0000_0001_001F_FE00);
      check("t6_addr_4096", fire_addr[4096], BASE1);
    end

    // Completion for a free tag is flagged and changes nothing else.
    retire_q.push_back(8'd5);
    tick(3);
    check("t7_tag_error",   tag_error, 1);
    check("t7_outstanding", outstanding, 0);
    check("t7_active",      active, 1);

    // Asynchronous reset while a request is pending.
    read_request_ready = 1'b0;
    pio(A_DISABLE, 64'd0);
    pio(A_ENABLE, 64'd0);
    check("t8_err_cleared", tag_error, 0);
    wait_valid(10);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t8_valid",       read_request_valid, 0);
    check("t8_active",      active, 0);
    check("t8_count",       request_count, 0);
    check("t8_outstanding", outstanding, 0);
    tick(1);
    reset = 1'b0;
    tick(4);
    check("t8_idle_after", read_request_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
